// File: rtl/window_convolve.sv
// KxK signed-coefficient window convolution: products, sum, then round/shift/saturate
// over three registered stages. window_in packs pixel [r][c] at bits (r*K+c)*8 +: 8.
module window_convolve #(
  parameter int KERNEL_SIZE = 3,
  parameter int ROW_WIDTH   = 640,
  parameter int ROW_COUNT   = 480,
  parameter int COEF_W      = 8,
  parameter int SHIFT       = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [8*KERNEL_SIZE*KERNEL_SIZE-1:0]     window_in,
  input  logic                                     in_valid,
  input  logic                                     coef_we,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0] coef_addr,
  input  logic [COEF_W-1:0]                        coef_data,
  input  logic                                     abs_en,
  output logic [7:0]                               out_pixel,
  output logic                                     out_valid,
  output logic                                     frame_done
);

  localparam int TAPS   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int ADDR_W = $clog2(TAPS);
  localparam int PROD_W = 8 + COEF_W + 1;
  localparam int SUM_W  = PROD_W + ADDR_W;
  localparam int COL_W  = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
  localparam int ROW_W  = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;
  localparam int CENTRE = (KERNEL_SIZE / 2) * KERNEL_SIZE + KERNEL_SIZE / 2;
  localparam logic signed [SUM_W:0] PIX_MAX = (SUM_W+1)'(255);

  logic signed [COEF_W-1:0] coef_reg [TAPS];
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic last_col, last_row, border, last_pixel;

  logic [TAPS-1:0][PROD_W-1:0] prod_next;
  logic [TAPS-1:0][PROD_W-1:0] prod_reg;
  logic v1_reg, abs1_reg, border1_reg, last1_reg;

  logic signed [SUM_W-1:0] sum_next, sum_reg;
  logic v2_reg, abs2_reg, border2_reg, last2_reg;

  logic signed [SUM_W:0] sum_ext, norm, neg;
  logic [7:0] sat;

  // Coefficient store; a write lands on the edge, so a same-cycle window sees the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++)
        coef_reg[i] <= (i == CENTRE) ? COEF_W'(2**SHIFT) : '0;
    end else if (coef_we && int'(coef_addr) < TAPS) begin
      coef_reg[coef_addr] <= coef_data;
    end
  end

  assign last_col   = (int'(col_reg) == ROW_WIDTH - 1);
  assign last_row   = (int'(row_reg) == ROW_COUNT - 1);
  assign border     = (int'(col_reg) < KERNEL_SIZE - 1) || (int'(row_reg) < KERNEL_SIZE - 1);
  assign last_pixel = last_col && last_row;

  always_ff @(posedge clk) begin
    if (reset) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (in_valid) begin
      if (last_col) begin
        col_reg <= '0;
        row_reg <= last_row ? '0 : row_reg + ROW_W'(1);
      end else begin
        col_reg <= col_reg + COL_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      logic signed [PROD_W-1:0] pix_ext, coef_ext;
      assign pix_ext  = {{(PROD_W-8){1'b0}}, window_in[gi*8 +: 8]};
      assign coef_ext = {{(PROD_W-COEF_W){coef_reg[gi][COEF_W-1]}}, coef_reg[gi]};
      assign prod_next[gi] = pix_ext * coef_ext;
    end
  endgenerate

  // Stage 1: products plus the position/mode flags that travel with them.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_reg    <= '0;
      v1_reg      <= 1'b0;
      abs1_reg    <= 1'b0;
      border1_reg <= 1'b0;
      last1_reg   <= 1'b0;
    end else begin
      if (in_valid) prod_reg <= prod_next;
      v1_reg      <= in_valid;
      abs1_reg    <= abs_en;
      border1_reg <= border;
      last1_reg   <= in_valid && last_pixel;
    end
  end

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < TAPS; i++)
      sum_next = sum_next + {{(SUM_W-PROD_W){prod_reg[i][PROD_W-1]}}, prod_reg[i]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_reg     <= '0;
      v2_reg      <= 1'b0;
      abs2_reg    <= 1'b0;
      border2_reg <= 1'b0;
      last2_reg   <= 1'b0;
    end else begin
      sum_reg     <= sum_next;
      v2_reg      <= v1_reg;
      abs2_reg    <= abs1_reg;
      border2_reg <= border1_reg;
      last2_reg   <= last1_reg;
    end
  end

  assign sum_ext = {sum_reg[SUM_W-1], sum_reg};

  generate
    if (SHIFT == 0) begin : g_noshift
      assign norm = sum_ext;
    end else begin : g_shift
      localparam logic signed [SUM_W:0] HALF = (SUM_W+1)'(2**(SHIFT-1));
      assign norm = (sum_ext + HALF) >>> SHIFT;
    end
  endgenerate

  always_comb begin
    sat = '0;
    neg = -norm;
    if (!border2_reg) begin
      if (norm[SUM_W]) begin
        if (abs2_reg) sat = (neg > PIX_MAX) ? 8'd255 : neg[7:0];
      end else if (norm > PIX_MAX) begin
        sat = 8'd255;
      end else begin
        sat = norm[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_pixel  <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_pixel  <= v2_reg ? sat : 8'd0;
      out_valid  <= v2_reg;
      frame_done <= v2_reg && last2_reg;
    end
  end

endmodule

// File: tb/tb_window_convolve.sv
// Directed + random stimulus for window_convolve, checked cycle-by-cycle against an
// arithmetic model that tracks image position and coefficients independently.
module tb_window_convolve;

  localparam int K = 3, RW = 8, RC = 4, CW = 8, SH = 4, TAPS = 9;

  logic clk = 1'b0;
  logic reset;
  logic [8*TAPS-1:0] window_in;
  logic in_valid, coef_we, abs_en;
  logic [3:0] coef_addr;
  logic [CW-1:0] coef_data;
  logic [7:0] out_pixel;
  logic out_valid, frame_done;

  window_convolve #(
    .KERNEL_SIZE(K), .ROW_WIDTH(RW), .ROW_COUNT(RC), .COEF_W(CW), .SHIFT(SH)
  ) dut (
    .clk(clk), .reset(reset), .window_in(window_in), .in_valid(in_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .abs_en(abs_en),
    .out_pixel(out_pixel), .out_valid(out_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int pix;
    bit fd;
  } exp_t;

  exp_t exp_q[$];
  int model_coef[TAPS];
  int win[TAPS];
  int pos;
  int tests = 0;
  int fails = 0;

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int expect_pixel(input bit absv);
    int s, n, col, row;
    col = pos % RW;
    row = pos / RW;
    if (col < K - 1 || row < K - 1) return 0;
    s = 0;
    for (int i = 0; i < TAPS; i++) s += win[i] * model_coef[i];
    n = floor_div(s + (1 << (SH - 1)), 1 << SH);
    if (n > 255) return 255;
    if (n < 0) return absv ? ((-n > 255) ? 255 : -n) : 0;
    return n;
  endfunction

  task automatic model_identity();
    for (int i = 0; i < TAPS; i++) model_coef[i] = 0;
    model_coef[(K/2)*K + K/2] = 1 << SH;
  endtask

  // One clock: record the expectation for this cycle's inputs, clock, then check the
  // output that belongs to the input three cycles back.
  task automatic cycle();
    exp_t e;
    for (int i = 0; i < TAPS; i++) window_in[i*8 +: 8] = win[i][7:0];
    e.v = 1'b0; e.pix = 0; e.fd = 1'b0;
    if (reset) begin
      foreach (exp_q[i]) begin
        exp_q[i].v = 1'b0; exp_q[i].pix = 0; exp_q[i].fd = 1'b0;
      end
    end else if (in_valid) begin
      e.v = 1'b1;
      e.pix = expect_pixel(abs_en);
      e.fd = (pos == RW*RC - 1);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (reset) begin
      pos = 0;
      model_identity();
    end else begin
      if (in_valid) pos = (pos + 1) % (RW*RC);
      if (coef_we && int'(coef_addr) < TAPS) model_coef[coef_addr] = int'($signed(coef_data));
    end
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      tests++;
      assert (out_valid === e.v) else begin
        fails++;
        $error("FAIL out_valid observed=%0b expected=%0b", out_valid, e.v);
      end
      tests++;
      assert (out_pixel === 8'(e.pix)) else begin
        fails++;
        $error("FAIL out_pixel observed=%0d expected=%0d", out_pixel, e.pix);
      end
      tests++;
      assert (frame_done === e.fd) else begin
        fails++;
        $error("FAIL frame_done observed=%0b expected=%0b", frame_done, e.fd);
      end
    end
  endtask

  task automatic drive(input bit v, input bit a);
    in_valid = v; abs_en = a; coef_we = 1'b0;
    cycle();
  endtask

  task automatic wcoef(input int addr, input int val);
    in_valid = 1'b0; coef_we = 1'b1; coef_addr = 4'(addr); coef_data = CW'(val);
    cycle();
    coef_we = 1'b0;
  endtask

  task automatic fill(input int val);
    for (int i = 0; i < TAPS; i++) win[i] = val;
  endtask

  task automatic rand_win();
    for (int i = 0; i < TAPS; i++) win[i] = int'($urandom_range(0, 255));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; coef_we = 1'b0; abs_en = 1'b0;
    coef_addr = '0; coef_data = '0; pos = 0;
    fill(0);
    model_identity();
    repeat (4) cycle();
    reset = 1'b0;

    // Identity frame: centre carries the pixel index, borders must read 0.
    for (int p = 0; p < RW*RC; p++) begin
      rand_win();
      win[4] = p;
      drive(1'b1, 1'b0);
    end

    // Box blur scaled by 2^SHIFT: 28 -> 252, 29 -> saturate.
    for (int i = 0; i < TAPS; i++) wcoef(i, 16);
    for (int p = 0; p < 21; p++) begin fill(28); drive(1'b1, 1'(p % 2)); end
    for (int p = 0; p < 3; p++) begin fill(29); drive(1'b1, 1'b0); end

    // Sobel-X scaled by 2^SHIFT; pixels 26..28 are interior.
    wcoef(0, -16); wcoef(1, 0); wcoef(2, 16);
    wcoef(3, -32); wcoef(4, 0); wcoef(5, 32);
    wcoef(6, -16); wcoef(7, 0); wcoef(8, 16);
    rand_win(); drive(1'b1, 1'b0);
    rand_win(); drive(1'b1, 1'b1);
    for (int r = 0; r < K; r++) begin win[r*K] = 100; win[r*K+1] = 100; win[r*K+2] = 0; end
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    for (int r = 0; r < K; r++) begin win[r*K] = 0; win[r*K+1] = 0; win[r*K+2] = 50; end
    drive(1'b1, 1'b0);
    rand_win(); drive(1'b1, 1'b1);
    rand_win(); drive(1'b1, 1'b0);
    // Gap straddling the last pixel of the frame.
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    rand_win(); drive(1'b1, 1'b0);

    // Coefficient write coincident with a valid window.
    for (int i = 0; i < TAPS; i++) wcoef(i, (i == 4) ? 16 : 0);
    for (int p = 0; p < 18; p++) begin rand_win(); drive(1'b1, 1'b0); end
    rand_win(); win[4] = 10;
    in_valid = 1'b1; abs_en = 1'b0; coef_we = 1'b1; coef_addr = 4'd4; coef_data = CW'(32);
    cycle();
    coef_we = 1'b0;
    rand_win(); win[4] = 10; drive(1'b1, 1'b0);

    // Random traffic: gaps, abs mode, coefficient writes including out-of-range addresses.
    repeat (220) begin
      rand_win();
      in_valid = ($urandom % 4) != 0;
      abs_en = 1'($urandom % 2);
      coef_we = ($urandom % 5) == 0;
      coef_addr = 4'($urandom % 16);
      coef_data = CW'(int'($urandom_range(0, 40)) - 20);
      cycle();
    end
    coef_we = 1'b0;

    // Reset with three pixels in flight, then a full post-reset frame.
    repeat (3) begin rand_win(); drive(1'b1, 1'b0); end
    reset = 1'b1; in_valid = 1'b0;
    cycle();
    reset = 1'b0;
    for (int p = 0; p < RW*RC; p++) begin
      rand_win();
      drive(1'b1, 1'($urandom % 2));
    end
    repeat (4) drive(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/window_convolve.md
WINDOW_CONVOLVE -- requirements
Module: window_convolve

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 3, giving the window edge length in pixels.
REQ-002 SHALL have parameter ROW_WIDTH, default 640, giving pixels per image row.
REQ-003 SHALL have parameter ROW_COUNT, default 480, giving rows per frame.
REQ-004 SHALL have parameter COEF_W, default 8, giving the signed two's-complement coefficient width.
REQ-005 SHALL have parameter SHIFT, default 4, giving the right-shift (normalisation) applied to the sum.
REQ-006 clk  input  1  clock, all logic on rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 window_in  input  8 x KERNEL_SIZE x KERNEL_SIZE  unsigned pixel window, [row][col]; row KERNEL_SIZE-1 is newest, col KERNEL_SIZE-1 is newest.
REQ-009 in_valid  input  1  window_in holds a window whose newest pixel is a real image pixel this cycle.
REQ-010 coef_we  input  1  coefficient write strobe.
REQ-011 coef_addr  input  clog2(KERNEL_SIZE*KERNEL_SIZE)  coefficient index, row*KERNEL_SIZE+col.
REQ-012 coef_data  input  COEF_W  signed coefficient value.
REQ-013 abs_en  input  1  when 1, output magnitude of the result instead of clamping negatives to 0.
REQ-014 out_pixel  output  8  filtered unsigned pixel.
REQ-015 out_valid  output  1  out_pixel valid this cycle.
REQ-016 frame_done  output  1  single-cycle pulse coincident with the last output pixel of a frame.

Function
REQ-017 SHALL compute, per in_valid window, S = sum over r,c of window_in[r][c] * coef[r][c], with no overflow (product width 8+COEF_W+1 signed; sum widened by clog2(KERNEL_SIZE*KERNEL_SIZE) bits).
REQ-018 SHALL be a 3-stage pipeline: S1 registers products, S2 registers sum, S3 registers normalised, saturated out_pixel; out_valid asserts exactly 3 cycles after the accepting in_valid edge.
REQ-019 SHALL accept in_valid on any cycle, including back-to-back every cycle, with no stall and no dropped pixel.
REQ-020 SHALL normalise as N = (S + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round-half-up); for SHIFT=0, N = S.
REQ-021 SHALL saturate: N>255 -> 255; N<0 -> 0 when abs_en=0, min(-N,255) when abs_en=1; abs_en is sampled with in_valid and pipelined alongside its data.
REQ-022 SHALL maintain col counter (0..ROW_WIDTH-1) and row counter (0..ROW_COUNT-1) advanced on each in_valid; col wraps to 0 and increments row; row wraps to 0 after last column of row ROW_COUNT-1.
REQ-023 SHALL treat a window as border when col < KERNEL_SIZE-1 or row < KERNEL_SIZE-1; border pixels SHALL still produce out_valid with out_pixel=0, so output count equals input count.
REQ-024 SHALL pulse frame_done with the out_valid of the pixel accepted at col=ROW_WIDTH-1, row=ROW_COUNT-1.
REQ-025 SHALL write coef[coef_addr] <= coef_data on coef_we; a write takes effect for in_valid windows from the following cycle; an in_valid in the same cycle as the write uses the old coefficient.
REQ-026 SHALL ignore coef_we with coef_addr >= KERNEL_SIZE*KERNEL_SIZE.
REQ-027 Cycles without in_valid SHALL not advance counters and SHALL produce out_valid=0 three cycles later.

Reset
REQ-028 On reset: out_pixel=0, out_valid=0, frame_done=0, all pipeline valid bits=0, col=0, row=0.
REQ-029 On reset: coefficients SHALL load the identity kernel: centre (KERNEL_SIZE/2, KERNEL_SIZE/2) = 2^SHIFT, all others 0.
REQ-030 Reset mid-frame SHALL discard all in-flight pipeline data (no out_valid in the following 3 cycles unless new in_valid) and restart counting at row 0, col 0.

Verification
REQ-031 Identity after reset, ROW_WIDTH=8, ROW_COUNT=4: stream pixels 0..31 with in_valid every cycle -> out_valid 3 cycles after each; border positions (row<2 or col<2) output 0; others output the centre pixel value.
REQ-032 Box blur: all coef=1, SHIFT=4... rather SHIFT=0 with all windows=28 -> S=252, out 252; all windows=29 -> S=261, out 255 (saturation).
REQ-033 Sobel-X coefs [-1 0 1; -2 0 2; -1 0 1], SHIFT=0, window cols 100/100/0 -> S=-400: abs_en=0 -> 0, abs_en=1 -> 255; cols 0/0/50 -> 200.
REQ-034 Coefficient write coincident with in_valid: centre changed 16->32, SHIFT=4, centre pixel 10 -> that pixel outputs 10, next pixel 10 outputs 20.
REQ-035 Gapped input (in_valid 1,0,0,1) across the last pixel of the frame -> frame_done pulses once with that pixel's out_valid; counters return to row 0, col 0.
REQ-036 Reset asserted with 3 pixels in flight -> no out_valid for those pixels; first post-reset pixel treated as row 0, col 0 (outputs 0).
